// File: rtl/adc_serial_capture.sv
// adc_serial_capture: serial-slave readout of NCH AD7643-class ADCs sharing
// CNVST/CS/SCLK, with single, continuous and counted-burst conversion modes and
// an internal frame FIFO drained by the FT600 transfer logic on the same clock.
//
// Ports:
//   CLK, RESETN        clock, synchronous active-low reset
//   MODE, START, STOP  run control (0 idle, 1 single, 2 continuous, 3 burst)
//   PERIOD, NSAMP      conversion period in CLK cycles, burst frame count
//   CLEAR              empties FIFO, clears flags, aborts to IDLE
//   ADCNVST/ADCS/ADSCLK  shared ADC controls (active-low CNVST/CS, SCLK idles low)
//   ADBUSY, ADSDOUT    per-channel BUSY and serial data
//   RD_EN, RD_DATA, RD_VALID  FIFO read port (data one cycle after accept)
//   LEVEL, EMPTY, FULL FIFO status
//   OVERFLOW, TIMEOUT  sticky error flags
//   ACTIVE, DONE       run in progress, one-cycle end-of-run pulse
module adc_serial_capture #(
    parameter int unsigned NCH       = 2,
    parameter int unsigned DATA_W    = 18,
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned SCLK_HALF = 2,
    parameter int unsigned CNV_LOW   = 4,
    parameter int unsigned BUSY_TMO  = 255,
    parameter int unsigned AW        = 12
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic [1:0]        MODE,
    input  logic              START,
    input  logic              STOP,
    input  logic [15:0]       PERIOD,
    input  logic [15:0]       NSAMP,
    input  logic              CLEAR,
    output logic              ADCNVST,
    output logic              ADCS,
    output logic              ADSCLK,
    input  logic [NCH-1:0]    ADBUSY,
    input  logic [NCH-1:0]    ADSDOUT,
    input  logic              RD_EN,
    output logic [OUT_W-1:0]  RD_DATA,
    output logic              RD_VALID,
    output logic [AW:0]       LEVEL,
    output logic              EMPTY,
    output logic              FULL,
    output logic              OVERFLOW,
    output logic              TIMEOUT,
    output logic              ACTIVE,
    output logic              DONE
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);
    localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNV,
        S_WAIT_BUSY,
        S_CS_SETUP,
        S_SHIFT,
        S_STORE,
        S_GAP
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [BIT_W-1:0]     r_bit;
    logic                 r_sclk;
    logic [15:0]          r_period_cnt;
    logic [15:0]          r_frames;
    logic [1:0]           r_mode;
    logic                 r_stop_seen;
    logic                 r_overflow;
    logic                 r_timeout;
    logic                 r_cnvst_n;
    logic                 r_cs_n;
    logic                 r_done;
    logic                 r_active;
    logic [DATA_W-1:0]    r_sh [NCH];

    logic [OUT_W-1:0]     r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [LW-1:0]        r_level;
    logic                 r_empty;
    logic                 r_full;
    logic                 r_rd_valid;
    logic [OUT_W-1:0]     r_rd_data;

    state_t               w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [BIT_W-1:0]     w_bit_nxt;
    logic                 w_sclk_nxt;
    logic                 w_shift_en;
    logic                 w_wr_en;
    logic [OUT_W-1:0]     w_wr_data;
    logic                 w_frame_inc;
    logic                 w_set_ovf;
    logic                 w_set_tmo;
    logic                 w_done_nxt;
    logic                 w_run_start;
    logic                 w_end_run;
    logic                 w_period_hit;
    logic [LW-1:0]        w_free;
    logic                 w_rd_acc;
    logic [LW-1:0]        w_level_nxt;
    logic                 w_rst;

    // CLEAR behaves exactly like reset
    assign w_rst = !RESETN || CLEAR;

    assign w_free       = LW'(DEPTH) - r_level;
    assign w_rd_acc     = RD_EN && !r_empty;
    assign w_period_hit = ({1'b0, r_period_cnt} + 17'd1) >= {1'b0, PERIOD};
    // STOP is honoured whether it arrived earlier in the run or in this cycle
    assign w_end_run    = (r_mode == 2'd1) || r_stop_seen || STOP || (MODE == 2'd0) ||
                          ((r_mode == 2'd3) && (r_frames >= NSAMP));

    // Next-state and per-state control
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_bit_nxt   = r_bit;
        w_sclk_nxt  = r_sclk;
        w_shift_en  = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_data   = r_sh[r_cnt[CH_W-1:0]][DATA_W-1 -: OUT_W];
        w_frame_inc = 1'b0;
        w_set_ovf   = 1'b0;
        w_set_tmo   = 1'b0;
        w_done_nxt  = 1'b0;
        w_run_start = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (START && (MODE != 2'd0)) begin
                    if ((MODE == 2'd3) && (NSAMP == 16'd0)) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_CNV;
                        w_run_start = 1'b1;
                    end
                end
            end
            S_CNV: begin
                if (r_cnt == CNT_W'(CNV_LOW - 1)) begin
                    w_state_nxt = S_WAIT_BUSY;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT_BUSY: begin
                // BUSY is ignored for the first two cycles so it has time to assert
                if ((r_cnt >= CNT_W'(2)) && (ADBUSY == '0)) begin
                    w_state_nxt = S_CS_SETUP;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= CNT_W'(BUSY_TMO - 1)) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = '0;
                    w_set_tmo   = 1'b1;
                    w_frame_inc = 1'b1;
                end
            end
            S_CS_SETUP: begin
                if (r_cnt == CNT_W'(SCLK_HALF - 1)) begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_sclk_nxt  = 1'b0;
                end
            end
            S_SHIFT: begin
                if (r_cnt == CNT_W'(SCLK_HALF - 1)) begin
                    w_cnt_nxt = '0;
                    if (!r_sclk) begin
                        // data sampled on the edge that raises SCLK
                        w_sclk_nxt = 1'b1;
                        w_shift_en = 1'b1;
                    end else begin
                        w_sclk_nxt = 1'b0;
                        if (r_bit == BIT_W'(DATA_W - 1)) begin
                            w_state_nxt = S_STORE;
                            w_bit_nxt   = '0;
                        end else begin
                            w_bit_nxt = r_bit + BIT_W'(1);
                        end
                    end
                end
            end
            S_STORE: begin
                // Room is decided once per frame; reads can only add room afterwards
                if ((r_cnt == '0) && (w_free < LW'(NCH))) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = '0;
                    w_set_ovf   = 1'b1;
                    w_frame_inc = 1'b1;
                end else begin
                    w_wr_en = 1'b1;
                    if (r_cnt == CNT_W'(NCH - 1)) begin
                        w_state_nxt = S_GAP;
                        w_cnt_nxt   = '0;
                        w_frame_inc = 1'b1;
                    end
                end
            end
            S_GAP: begin
                w_cnt_nxt = '0;
                if (w_end_run) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_period_hit) begin
                    w_state_nxt = S_CNV;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // FSM state, run bookkeeping and registered ADC controls
    always_ff @(posedge CLK) begin
        if (w_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_sclk       <= 1'b0;
            r_period_cnt <= '0;
            r_frames     <= '0;
            r_mode       <= '0;
            r_stop_seen  <= 1'b0;
            r_overflow   <= 1'b0;
            r_timeout    <= 1'b0;
            r_cnvst_n    <= 1'b1;
            r_cs_n       <= 1'b1;
            r_done       <= 1'b0;
            r_active     <= 1'b0;
            for (int unsigned c = 0; c < NCH; c++) begin
                r_sh[c] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_sclk    <= w_sclk_nxt;
            r_cnvst_n <= (w_state_nxt != S_CNV);
            r_cs_n    <= !((w_state_nxt == S_CS_SETUP) || (w_state_nxt == S_SHIFT));
            r_done    <= w_done_nxt;
            r_active  <= (w_state_nxt != S_IDLE);

            // Period measured from each CNV entry
            if ((w_state_nxt == S_CNV) && (r_state != S_CNV)) begin
                r_period_cnt <= '0;
            end else if (r_period_cnt != 16'hFFFF) begin
                r_period_cnt <= r_period_cnt + 16'd1;
            end

            if (w_run_start) begin
                r_frames <= '0;
                r_mode   <= MODE;
            end else if (w_frame_inc) begin
                r_frames <= r_frames + 16'd1;
            end

            if (w_state_nxt == S_IDLE) begin
                r_stop_seen <= 1'b0;
            end else if (STOP && (r_state != S_IDLE)) begin
                r_stop_seen <= 1'b1;
            end

            if (w_set_ovf) begin
                r_overflow <= 1'b1;
            end
            if (w_set_tmo) begin
                r_timeout <= 1'b1;
            end

            if (w_shift_en) begin
                for (int unsigned c = 0; c < NCH; c++) begin
                    r_sh[c] <= {r_sh[c][DATA_W-2:0], ADSDOUT[c]};
                end
            end
        end
    end

    // FIFO level bookkeeping
    always_comb begin
        w_level_nxt = r_level;
        if (w_wr_en && !w_rd_acc) begin
            w_level_nxt = r_level + LW'(1);
        end else if (!w_wr_en && w_rd_acc) begin
            w_level_nxt = r_level - LW'(1);
        end
    end

    // FIFO storage (unreset; pointers define validity)
    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    // FIFO pointers, status and read port
    always_ff @(posedge CLK) begin
        if (w_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_rd_data <= r_mem[r_rd_ptr];
            end
            r_rd_valid <= w_rd_acc;
            r_level    <= w_level_nxt;
            r_empty    <= (w_level_nxt == '0);
            r_full     <= (w_level_nxt == LW'(DEPTH));
        end
    end

    assign ADCNVST  = r_cnvst_n;
    assign ADCS     = r_cs_n;
    assign ADSCLK   = r_sclk;
    assign RD_DATA  = r_rd_data;
    assign RD_VALID = r_rd_valid;
    assign LEVEL    = r_level;
    assign EMPTY    = r_empty;
    assign FULL     = r_full;
    assign OVERFLOW = r_overflow;
    assign TIMEOUT  = r_timeout;
    assign ACTIVE   = r_active;
    assign DONE     = r_done;

endmodule

// File: tb/tb_adc_serial_capture.sv
// Testbench for adc_serial_capture: two ADC models (BUSY pulse after CNVST fall,
// MSB-first SDOUT advanced on SCLK falling edges), a negedge monitor counting
// CS-low cycles, DONE pulses and CNVST falling-edge times, and directed checks.
module tb_adc_serial_capture;

    localparam int unsigned NCH       = 2;
    localparam int unsigned DATA_W    = 18;
    localparam int unsigned OUT_W     = 16;
    localparam int unsigned SCLK_HALF = 2;
    localparam int unsigned CNV_LOW   = 4;
    localparam int unsigned BUSY_TMO  = 255;
    localparam int unsigned AW        = 2;

    logic              CLK = 1'b0;
    logic              RESETN, START, STOP, CLEAR, RD_EN;
    logic [1:0]        MODE;
    logic [15:0]       PERIOD, NSAMP;
    logic              ADCNVST, ADCS, ADSCLK;
    logic [NCH-1:0]    ADBUSY = '0;
    logic [NCH-1:0]    ADSDOUT = '0;
    logic [OUT_W-1:0]  RD_DATA;
    logic              RD_VALID;
    logic [AW:0]       LEVEL;
    logic              EMPTY, FULL, OVERFLOW, TIMEOUT, ACTIVE, DONE;

    always #5 CLK = ~CLK;

    adc_serial_capture #(
        .NCH(NCH), .DATA_W(DATA_W), .OUT_W(OUT_W), .SCLK_HALF(SCLK_HALF),
        .CNV_LOW(CNV_LOW), .BUSY_TMO(BUSY_TMO), .AW(AW)
    ) dut (
        .CLK(CLK), .RESETN(RESETN), .MODE(MODE), .START(START), .STOP(STOP),
        .PERIOD(PERIOD), .NSAMP(NSAMP), .CLEAR(CLEAR),
        .ADCNVST(ADCNVST), .ADCS(ADCS), .ADSCLK(ADSCLK),
        .ADBUSY(ADBUSY), .ADSDOUT(ADSDOUT),
        .RD_EN(RD_EN), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
        .LEVEL(LEVEL), .EMPTY(EMPTY), .FULL(FULL),
        .OVERFLOW(OVERFLOW), .TIMEOUT(TIMEOUT), .ACTIVE(ACTIVE), .DONE(DONE)
    );

    // ADC models and monitor
    logic [DATA_W-1:0] samp [NCH];
    logic [NCH-1:0]    stuck = '0;
    int                bit_idx = 0;
    int                busy_cnt = 0;
    logic              prev_sclk = 1'b0;
    logic              prev_cnv = 1'b1;
    int                cyc = 0;
    int                cs_low_cnt = 0;
    int                done_cnt = 0;
    int                cnv_cnt = 0;
    int                cnv_t [64];

    always @(negedge CLK) begin
        logic [DATA_W-1:0] s;
        cyc = cyc + 1;
        if (ADCS === 1'b1) bit_idx = 0;
        else if (prev_sclk === 1'b1 && ADSCLK === 1'b0) bit_idx = bit_idx + 1;
        prev_sclk = ADSCLK;
        if (prev_cnv === 1'b1 && ADCNVST === 1'b0) begin
            busy_cnt = 10;
            if (cnv_cnt < 64) cnv_t[cnv_cnt] = cyc;
            cnv_cnt = cnv_cnt + 1;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
        end
        prev_cnv = ADCNVST;
        for (int c = 0; c < NCH; c++) begin
            s = samp[c];
            ADSDOUT[c] = (bit_idx < DATA_W) ? s[DATA_W-1-bit_idx] : 1'b0;
            ADBUSY[c]  = stuck[c] | (busy_cnt > 0);
        end
        if (ADCS === 1'b0) cs_low_cnt = cs_low_cnt + 1;
        if (DONE === 1'b1) done_cnt = done_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick(1);
        START = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (DONE !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        chk(name, 32'(DONE), 32'd1);
    endtask

    task automatic wait_cnv(input int n, input int budget, input string name);
        int k = 0;
        while (cnv_cnt < n && k < budget) begin
            tick(1);
            k++;
        end
        chk(name, 32'(cnv_cnt >= n), 32'd1);
    endtask

    task automatic wait_sclk_high(input int budget, input string name);
        int k = 0;
        while (ADSCLK !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        chk(name, 32'(ADSCLK), 32'd1);
    endtask

    task automatic read_word(input logic [15:0] exp, input string name);
        RD_EN = 1'b1;
        tick(1);
        RD_EN = 1'b0;
        chk({name, " valid"}, 32'(RD_VALID), 32'd1);
        chk(name, 32'(RD_DATA), 32'(exp));
    endtask

    typedef struct {
        logic [DATA_W-1:0] s0;
        logic [DATA_W-1:0] s1;
        logic [OUT_W-1:0]  e0;
        logic [OUT_W-1:0]  e1;
        int                cs_low;
    } vec_t;

    vec_t vt [4];

    initial begin
        int cs0, d0, n0, k;

        // single-shot vectors: samples and their upper 16 bits
        vt[0] = '{18'h2ABCD, 18'h15555, 16'hAAF3, 16'h5555, 2 + 18 * 4};
        vt[1] = '{18'h3FFFF, 18'h00000, 16'hFFFF, 16'h0000, 2 + 18 * 4};
        vt[2] = '{18'h00003, 18'h3FFFC, 16'h0000, 16'hFFFF, 2 + 18 * 4};
        vt[3] = '{18'h12345, 18'h2468A, 16'h48D1, 16'h91A2, 2 + 18 * 4};

        RESETN = 1'b0; START = 1'b0; STOP = 1'b0; CLEAR = 1'b0; RD_EN = 1'b0;
        MODE = 2'd0; PERIOD = 16'd200; NSAMP = 16'd0;
        samp[0] = vt[0].s0; samp[1] = vt[0].s1;
        tick(3);

        chk("rst ADCNVST", 32'(ADCNVST), 32'd1);
        chk("rst ADCS", 32'(ADCS), 32'd1);
        chk("rst ADSCLK", 32'(ADSCLK), 32'd0);
        chk("rst EMPTY", 32'(EMPTY), 32'd1);
        chk("rst LEVEL", 32'(LEVEL), 32'd0);
        chk("rst RD_VALID", 32'(RD_VALID), 32'd0);
        chk("rst OVERFLOW", 32'(OVERFLOW), 32'd0);
        chk("rst TIMEOUT", 32'(TIMEOUT), 32'd0);
        chk("rst DONE", 32'(DONE), 32'd0);
        chk("rst ACTIVE", 32'(ACTIVE), 32'd0);
        RESETN = 1'b1;
        tick(2);

        // MODE=0 start ignored
        n0 = cnv_cnt;
        pulse_start();
        tick(20);
        chk("mode0 no cnv", 32'(cnv_cnt), 32'(n0));
        chk("mode0 idle", 32'(ACTIVE), 32'd0);

        // single-shot table; 4 frames x 2 words also wrap the read pointer twice
        for (int i = 0; i < 4; i++) begin
            samp[0] = vt[i].s0;
            samp[1] = vt[i].s1;
            cs0 = cs_low_cnt;
            d0  = done_cnt;
            MODE = 2'd1;
            pulse_start();
            wait_done(2000, "single done");
            tick(2);
            chk("single level", 32'(LEVEL), 32'd2);
            chk("single cs low cycles", 32'(cs_low_cnt - cs0), 32'(vt[i].cs_low));
            chk("single done count", 32'(done_cnt - d0), 32'd1);
            chk("single idle", 32'(ACTIVE), 32'd0);
            read_word(vt[i].e0, "single ch0");
            read_word(vt[i].e1, "single ch1");
            chk("single empty", 32'(EMPTY), 32'd1);
        end

        // continuous: period spacing, read concurrent with store, STOP mid-shift
        samp[0] = vt[0].s0; samp[1] = vt[0].s1;
        MODE = 2'd2; PERIOD = 16'd200;
        n0 = cnv_cnt;
        d0 = done_cnt;
        pulse_start();
        wait_cnv(n0 + 3, 800, "cont 3 conversions");
        chk("cont spacing 1", 32'(cnv_t[n0+1] - cnv_t[n0]), 32'd200);
        chk("cont spacing 2", 32'(cnv_t[n0+2] - cnv_t[n0+1]), 32'd200);
        chk("cont level 2 frames", 32'(LEVEL), 32'd4);
        read_word(16'hAAF3, "cont f1 ch0");
        read_word(16'h5555, "cont f1 ch1");
        wait_sclk_high(300, "cont reach shift");
        STOP = 1'b1;
        tick(1);
        STOP = 1'b0;
        k = 0;
        while (ADCS !== 1'b1 && k < 300) begin
            tick(1);
            k++;
        end
        chk("cont cs released", 32'(ADCS), 32'd1);
        chk("cont level before store", 32'(LEVEL), 32'd2);
        RD_EN = 1'b1;
        tick(1);
        RD_EN = 1'b0;
        chk("level on read+write", 32'(LEVEL), 32'd2);
        chk("rw valid", 32'(RD_VALID), 32'd1);
        chk("rw data", 32'(RD_DATA), 32'hAAF3);
        wait_done(300, "cont done");
        tick(2);
        chk("cont level after stop", 32'(LEVEL), 32'd3);
        chk("cont no overflow", 32'(OVERFLOW), 32'd0);
        read_word(16'h5555, "cont f2 ch1");
        read_word(16'hAAF3, "cont f3 ch0");
        read_word(16'h5555, "cont f3 ch1");
        tick(300);
        chk("cont no restart", 32'(cnv_cnt), 32'(n0 + 3));
        chk("cont done count", 32'(done_cnt - d0), 32'd1);

        // burst of 3 into a 4-word FIFO with no reads
        MODE = 2'd3; NSAMP = 16'd3; PERIOD = 16'd200;
        n0 = cnv_cnt;
        d0 = done_cnt;
        pulse_start();
        wait_cnv(n0 + 2, 500, "burst 2nd cnv");
        chk("burst level f1", 32'(LEVEL), 32'd2);
        wait_cnv(n0 + 3, 500, "burst 3rd cnv");
        chk("burst level f2", 32'(LEVEL), 32'd4);
        chk("burst full f2", 32'(FULL), 32'd1);
        chk("burst ovf before f3", 32'(OVERFLOW), 32'd0);
        wait_done(500, "burst done");
        tick(2);
        chk("burst level end", 32'(LEVEL), 32'd4);
        chk("burst overflow", 32'(OVERFLOW), 32'd1);
        chk("burst full end", 32'(FULL), 32'd1);
        chk("burst done count", 32'(done_cnt - d0), 32'd1);
        chk("burst cnv count", 32'(cnv_cnt), 32'(n0 + 3));

        // burst with NSAMP=0 ends immediately
        NSAMP = 16'd0;
        d0 = done_cnt;
        pulse_start();
        chk("nsamp0 done", 32'(DONE), 32'd1);
        tick(2);
        chk("nsamp0 idle", 32'(ACTIVE), 32'd0);
        chk("nsamp0 no cnv", 32'(cnv_cnt), 32'(n0 + 3));
        chk("nsamp0 done count", 32'(done_cnt - d0), 32'd1);

        // CLEAR with three words stored
        read_word(16'hAAF3, "pre clear read");
        chk("pre clear level", 32'(LEVEL), 32'd3);
        CLEAR = 1'b1;
        tick(1);
        CLEAR = 1'b0;
        chk("clear level", 32'(LEVEL), 32'd0);
        chk("clear empty", 32'(EMPTY), 32'd1);
        chk("clear full", 32'(FULL), 32'd0);
        chk("clear overflow", 32'(OVERFLOW), 32'd0);

        // BUSY stuck on channel 1
        stuck = 2'b10;
        MODE = 2'd2; PERIOD = 16'd300;
        n0 = cnv_cnt;
        pulse_start();
        wait_cnv(n0 + 2, 800, "tmo 2nd cnv");
        chk("tmo spacing", 32'(cnv_t[n0+1] - cnv_t[n0]), 32'd300);
        chk("tmo flag", 32'(TIMEOUT), 32'd1);
        chk("tmo nothing stored", 32'(LEVEL), 32'd0);
        STOP = 1'b1;
        tick(1);
        STOP = 1'b0;
        wait_done(700, "tmo done");
        stuck = 2'b00;
        chk("tmo empty", 32'(EMPTY), 32'd1);

        // read on empty is ignored
        RD_EN = 1'b1;
        tick(1);
        RD_EN = 1'b0;
        chk("empty read valid", 32'(RD_VALID), 32'd0);
        chk("empty read level", 32'(LEVEL), 32'd0);

        // reset in the middle of SHIFT
        MODE = 2'd1;
        pulse_start();
        wait_sclk_high(300, "reset reach shift");
        RESETN = 1'b0;
        tick(1);
        chk("midrst ADCS", 32'(ADCS), 32'd1);
        chk("midrst ADSCLK", 32'(ADSCLK), 32'd0);
        chk("midrst ADCNVST", 32'(ADCNVST), 32'd1);
        chk("midrst EMPTY", 32'(EMPTY), 32'd1);
        chk("midrst ACTIVE", 32'(ACTIVE), 32'd0);
        chk("midrst TIMEOUT", 32'(TIMEOUT), 32'd0);
        RESETN = 1'b1;
        tick(200);
        chk("midrst no store", 32'(LEVEL), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/adc_serial_capture.md
Name: adc_serial_capture

Overview:
Parametrised successor to the single-channel AD7643 serial-readout logic in the MAX10 ADC controller. Drives a shared CNVST/CS/SCLK to NCH AD7643-class ADCs in serial slave mode and shifts DATA_W-bit samples from each SDOUT in parallel. Supports single-shot, continuous and counted-burst conversion modes. Stores frames in an internal FIFO that the FT600 transfer logic drains on the same clock.

Parameters:
NCH, 2, number of ADC channels sharing CNVST/CS/SCLK
DATA_W, 18, ADC sample width, shifted MSB first
OUT_W, 16, stored word width; upper OUT_W bits of each sample are kept (OUT_W <= DATA_W)
SCLK_HALF, 2, CLK cycles per SCLK half-period (>=1)
CNV_LOW, 4, CLK cycles ADCNVST held low
BUSY_TMO, 255, max CLK cycles in WAIT_BUSY before timeout
AW, 12, FIFO address width; depth = 2^AW words

Ports:
CLK  in  1  system clock; all logic on rising edge
RESETN  in  1  synchronous reset, active low
MODE  in  2  0 idle, 1 single, 2 continuous, 3 burst
START  in  1  one-cycle start pulse; sampled only in IDLE
STOP  in  1  ends continuous/burst after the current frame
PERIOD  in  16  CLK cycles between conversion starts (modes 2/3)
NSAMP  in  16  frame count for burst mode
CLEAR  in  1  pointer clear: empty FIFO, clear flags, abort to IDLE
ADCNVST  out  1  conversion start, active low
ADCS  out  1  chip select, active low
ADSCLK  out  1  serial clock, idles low
ADBUSY  in  NCH  per-channel BUSY
ADSDOUT  in  NCH  per-channel serial data
RD_EN  in  1  FIFO read request
RD_DATA  out  OUT_W  FIFO read data
RD_VALID  out  1  RD_DATA valid, one cycle after an accepted RD_EN
LEVEL  out  AW+1  words in FIFO
EMPTY  out  1  LEVEL==0
FULL  out  1  LEVEL==2^AW
OVERFLOW  out  1  sticky: a frame was dropped
TIMEOUT  out  1  sticky: BUSY timeout occurred
ACTIVE  out  1  FSM not in IDLE
DONE  out  1  one-cycle pulse when a run ends

Behaviour:
- Reset (RESETN=0 at a rising CLK edge): ADCNVST=1, ADCS=1, ADSCLK=0, FIFO empty, RD_VALID=0, OVERFLOW=TIMEOUT=0, DONE=0, FSM=IDLE, frame/period counters 0. Takes effect mid-frame without completing the frame.
- CLEAR: same effect as reset on all state and outputs; lower priority than RESETN.
- FSM states: IDLE, CNV, WAIT_BUSY, CS_SETUP, SHIFT, STORE, GAP.
- IDLE: START with MODE!=0 -> CNV. With MODE=3 and NSAMP=0 -> DONE pulse, stay IDLE. START with MODE=0 is ignored.
- CNV: ADCNVST=0 for CNV_LOW cycles; the period counter restarts at 0 on CNV entry. Then ADCNVST=1 -> WAIT_BUSY.
- WAIT_BUSY: exit once ADBUSY is all zero, qualified only after 2 cycles in the state. If BUSY_TMO cycles elapse first: set TIMEOUT, discard frame, go to GAP.
- CS_SETUP: ADCS=0 for SCLK_HALF cycles -> SHIFT.
- SHIFT: DATA_W SCLK periods, each low half then high half. On the cycle ADSCLK goes 0->1, shift ADSDOUT[c] into shift register c. After DATA_W bits: ADSCLK=0, ADCS=1 -> STORE.
- STORE: if free words >= NCH, write NCH words in NCH consecutive cycles, channel 0 first, word = sample[DATA_W-1 -: OUT_W]. Otherwise write nothing and set OVERFLOW; frames are never partially stored. Then frames_done++ and go to GAP.
- GAP:
  - MODE 1: -> IDLE with DONE.
  - MODE 2/3: wait until period counter >= PERIOD-1, then -> CNV. If PERIOD is shorter than the frame, restart on the next cycle.
  - MODE 3: when frames_done==NSAMP -> IDLE with DONE.
  - STOP seen at any time during a run, or MODE=0: -> IDLE with DONE at the next GAP.
- Timed-out frames count toward NSAMP.
- FIFO:
  - RD_EN accepted only when not EMPTY; RD_EN on EMPTY is ignored (RD_VALID stays 0, pointers unchanged).
  - Simultaneous write and read in one cycle is legal; LEVEL is unchanged.
  - Pointers wrap modulo 2^AW.
  - RD_DATA holds its value when not reading.

Test Plan:
- Single, NCH=2, ADC models return 18'h2ABCD/18'h15555, BUSY 10 cycles: START MODE=1 -> FIFO holds 16'hAAF3, 16'h5555 in order; DONE pulses once; ADCS low for exactly 2+18*4 cycles.
- Continuous, PERIOD=200: CNV falling edges spaced exactly 200 cycles apart; STOP mid-SHIFT -> current frame is stored, then IDLE + DONE.
- Burst NSAMP=3 with AW=2 (depth 4), no reads: frame 1 stored (LEVEL=2), frame 2 stored (LEVEL=4, FULL), frame 3 dropped, OVERFLOW=1, LEVEL stays 4, DONE after frame 3.
- ADBUSY[1] stuck high, BUSY_TMO=255: TIMEOUT=1, nothing written, next conversion still starts on PERIOD schedule.
- RESETN=0 during SHIFT -> next cycle ADCS=1, ADSCLK=0, ADCNVST=1, EMPTY=1; CLEAR with LEVEL=3 -> LEVEL=0, flags cleared.
- Read while STORE writes: LEVEL is constant across that cycle; RD_EN on EMPTY -> RD_VALID=0; read pointer wraps after 2^AW reads with data order preserved.
